qspi_line_arb: RTL and testbench

Cache-side front end for the `qspi` flash/PSRAM controller. Arbitrates instruction-cache and data-cache line misses and data-cache line writebacks, and decodes each line address to a chip select (`mem`) using `rom_mode`. Drives the controller's `req`/`i_d`/`mem`/`write`/`paddr` for one line, streams write nibbles on `dwrite` against `rstrobe_d`, assembles read nibbles from the pad input on `wstrobe_i`/`wstrobe_d`, and returns whole lines to the caches.

---
 rtl/qspi_line_arb.sv | 241 ++++++++++++++++++++++++
 tb/tb_qspi_line_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_line_arb.sv
// Line-level front end for the qspi controller: arbitrates I/D cache line transfers and packs/unpacks nibbles.
// Optional one-line posted write buffer enabled by defining QSPI_LINE_ARB_WBUF_EN.
module qspi_line_arb #(
   parameter int LINE_LENGTH = 4,
   parameter int PA          = 24
) (
   input  logic                                clk,
   input  logic                                reset_n,
   input  logic                                ic_req,
   input  logic [PA-$clog2(LINE_LENGTH)-1:0]   ic_addr,
   output logic                                ic_done,
   output logic [8*LINE_LENGTH-1:0]            ic_rdata,
   input  logic                                dc_req,
   input  logic                                dc_write,
   input  logic [PA-$clog2(LINE_LENGTH)-1:0]   dc_addr,
   input  logic [8*LINE_LENGTH-1:0]            dc_wdata,
   output logic                                dc_done,
   output logic [8*LINE_LENGTH-1:0]            dc_rdata,
   input  logic [1:0]                          rom_mode,
   input  logic [3:0]                          pad_in,
   output logic                                req,
   output logic                                i_d,
   output logic                                write,
   output logic [1:0]                          mem,
   output logic [PA-$clog2(LINE_LENGTH)-1:0]   paddr,
   input  logic                                rstrobe_d,
   input  logic                                wstrobe_i,
   input  logic                                wstrobe_d,
   output logic [3:0]                          dwrite
);

   localparam int LA = PA - $clog2(LINE_LENGTH);
   localparam int LB = 8 * LINE_LENGTH;
   localparam int NN = 2 * LINE_LENGTH;
   localparam int NW = $clog2(NN);
   localparam int OW = $clog2(LB);

   typedef enum logic [1:0] {IDLE, RD, WR} state_t;

   state_t          state_q, state_d;
   logic            preferI_q, preferI_d;
   logic [NW-1:0]   nidx_q, nidx_d;
   logic [LB-1:0]   lbuf_q, lbuf_d;
   logic            req_q, req_d;
   logic            iD_q, iD_d;
   logic            write_q, write_d;
   logic [1:0]      mem_q, mem_d;
   logic [LA-1:0]   paddr_q, paddr_d;
   logic            icDone_q, icDone_d;
   logic            dcDone_q, dcDone_d;
   logic [LB-1:0]   icRdata_q, icRdata_d;
   logic [LB-1:0]   dcRdata_q, dcRdata_d;
`ifdef QSPI_LINE_ARB_WBUF_EN
   logic            wbufFull_q, wbufFull_d;
   logic [LB-1:0]   wbuf_q, wbuf_d;
   logic [LA-1:0]   wbufAddr_q, wbufAddr_d;
`endif

   logic            icGo, dcGo, dcCand, strobe, lastNib;
   logic [OW-1:0]   nibOff;

   function automatic logic [1:0] decodeMem(input logic [1:0] mode, input logic isI, input logic msb);
      logic [1:0] m;
      case (mode)
         2'b00:   m = msb ? 2'd2 : 2'd0;
         2'b10:   m = msb ? 2'd1 : 2'd0;
         2'b11:   m = (isI && msb) ? 2'd1 : 2'd0;
         default: m = 2'd0;
      endcase
      return m;
   endfunction

   // A request is still high during its own done cycle; it is only a new request one cycle later.
   assign icGo    = ic_req & ~icDone_q;
   assign dcGo    = dc_req & ~dcDone_q;
`ifdef QSPI_LINE_ARB_WBUF_EN
   assign dcCand  = dcGo & ~dc_write;
`else
   assign dcCand  = dcGo;
`endif
   assign strobe  = iD_q ? wstrobe_i : wstrobe_d;
   assign lastNib = (nidx_q == NW'(NN - 1));
   assign nibOff  = {nidx_q[NW-1:1], ~nidx_q[0], 2'b00};

   always_comb begin
      state_d   = state_q;
      preferI_d = preferI_q;
      nidx_d    = nidx_q;
      lbuf_d    = lbuf_q;
      req_d     = req_q;
      iD_d      = iD_q;
      write_d   = write_q;
      mem_d     = mem_q;
      paddr_d   = paddr_q;
      icDone_d  = 1'b0;
      dcDone_d  = 1'b0;
      icRdata_d = icRdata_q;
      dcRdata_d = dcRdata_q;
`ifdef QSPI_LINE_ARB_WBUF_EN
      wbufFull_d = wbufFull_q;
      wbuf_d     = wbuf_q;
      wbufAddr_d = wbufAddr_q;
`endif
      unique case (state_q)
         IDLE: begin
`ifdef QSPI_LINE_ARB_WBUF_EN
            if (wbufFull_q) begin
               req_d   = 1'b1;
               iD_d    = 1'b0;
               write_d = 1'b1;
               mem_d   = decodeMem(rom_mode, 1'b0, wbufAddr_q[LA-1]);
               paddr_d = wbufAddr_q;
               lbuf_d  = wbuf_q;
               nidx_d  = '0;
               state_d = WR;
            end else
`endif
            // Ties go to whichever side did not win last; after reset D wins first.
            if (icGo && (!dcCand || preferI_q)) begin
               req_d     = 1'b1;
               iD_d      = 1'b1;
               write_d   = 1'b0;
               mem_d     = decodeMem(rom_mode, 1'b1, ic_addr[LA-1]);
               paddr_d   = ic_addr;
               nidx_d    = '0;
               preferI_d = 1'b0;
               state_d   = RD;
            end else if (dcCand) begin
               req_d     = 1'b1;
               iD_d      = 1'b0;
               write_d   = dc_write;
               mem_d     = decodeMem(rom_mode, 1'b0, dc_addr[LA-1]);
               paddr_d   = dc_addr;
               nidx_d    = '0;
               preferI_d = 1'b1;
               if (dc_write) begin
                  lbuf_d  = dc_wdata;
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            if (strobe) begin
               lbuf_d[nibOff +: 4] = pad_in;
               nidx_d              = nidx_q + 1'b1;
               if (lastNib) begin
                  req_d   = 1'b0;
                  state_d = IDLE;
                  if (iD_q) begin
                     icDone_d  = 1'b1;
                     icRdata_d = lbuf_d;
                  end else begin
                     dcDone_d  = 1'b1;
                     dcRdata_d = lbuf_d;
                  end
               end
            end
         end
         WR: begin
            if (rstrobe_d) begin
               nidx_d = nidx_q + 1'b1;
               if (lastNib) begin
                  req_d   = 1'b0;
                  state_d = IDLE;
`ifdef QSPI_LINE_ARB_WBUF_EN
                  wbufFull_d = 1'b0;
`else
                  dcDone_d   = 1'b1;
`endif
               end
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef QSPI_LINE_ARB_WBUF_EN
      // Posted writeback: acknowledged as soon as it lands in the empty buffer, whatever the FSM is doing.
      if (!wbufFull_q && dcGo && dc_write) begin
         wbufFull_d = 1'b1;
         wbuf_d     = dc_wdata;
         wbufAddr_d = dc_addr;
         dcDone_d   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         preferI_q  <= 1'b0;
         nidx_q     <= '0;
         lbuf_q     <= '0;
         req_q      <= 1'b0;
         iD_q       <= 1'b0;
         write_q    <= 1'b0;
         mem_q      <= 2'd0;
         paddr_q    <= '0;
         icDone_q   <= 1'b0;
         dcDone_q   <= 1'b0;
         icRdata_q  <= '0;
         dcRdata_q  <= '0;
`ifdef QSPI_LINE_ARB_WBUF_EN
         wbufFull_q <= 1'b0;
         wbuf_q     <= '0;
         wbufAddr_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         preferI_q  <= preferI_d;
         nidx_q     <= nidx_d;
         lbuf_q     <= lbuf_d;
         req_q      <= req_d;
         iD_q       <= iD_d;
         write_q    <= write_d;
         mem_q      <= mem_d;
         paddr_q    <= paddr_d;
         icDone_q   <= icDone_d;
         dcDone_q   <= dcDone_d;
         icRdata_q  <= icRdata_d;
         dcRdata_q  <= dcRdata_d;
`ifdef QSPI_LINE_ARB_WBUF_EN
         wbufFull_q <= wbufFull_d;
         wbuf_q     <= wbuf_d;
         wbufAddr_q <= wbufAddr_d;
`endif
      end
   end

   assign req      = req_q;
   assign i_d      = iD_q;
   assign write    = write_q;
   assign mem      = mem_q;
   assign paddr    = paddr_q;
   assign ic_done  = icDone_q;
   assign dc_done  = dcDone_q;
   assign ic_rdata = icRdata_q;
   assign dc_rdata = dcRdata_q;
   assign dwrite   = lbuf_q[nibOff +: 4];

endmodule

// File: tb/tb_qspi_line_arb.sv
// Self-checking bench for qspi_line_arb (default build): directed and random line transfers against a line-level model.
module tb_qspi_line_arb;

   localparam int LL = 4;
   localparam int PA = 24;
   localparam int LA = 22;

   logic          clk, reset_n;
   logic          ic_req, ic_done, dc_req, dc_write, dc_done;
   logic [LA-1:0] ic_addr, dc_addr, paddr;
   logic [31:0]   ic_rdata, dc_rdata, dc_wdata;
   logic [1:0]    rom_mode, mem;
   logic [3:0]    pad_in, dwrite;
   logic          req, i_d, write, rstrobe_d, wstrobe_i, wstrobe_d;

   int            checks = 0;
   int            errors = 0;
   logic [31:0]   expIcLine = '0;
   logic [31:0]   expDcLine = '0;

   qspi_line_arb #(.LINE_LENGTH(LL), .PA(PA)) dut (
      .clk(clk), .reset_n(reset_n),
      .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_rdata(ic_rdata),
      .dc_req(dc_req), .dc_write(dc_write), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_done(dc_done), .dc_rdata(dc_rdata),
      .rom_mode(rom_mode), .pad_in(pad_in),
      .req(req), .i_d(i_d), .write(write), .mem(mem), .paddr(paddr),
      .rstrobe_d(rstrobe_d), .wstrobe_i(wstrobe_i), .wstrobe_d(wstrobe_d), .dwrite(dwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Chip-select table, written straight from the rom_mode rules.
   function automatic logic [1:0] refMem(input logic [1:0] mode, input bit isI, input logic [LA-1:0] addr);
      bit a;
      a = addr[LA-1];
      if (mode == 2'b01) return 2'd0;
      if (mode == 2'b00) return a ? 2'd2 : 2'd0;
      if (mode == 2'b10) return a ? 2'd1 : 2'd0;
      return (isI && a) ? 2'd1 : 2'd0;
   endfunction

   // Stream nibble k is held in nibs[4k+:4]; byte b is (nibble 2b, nibble 2b+1) high then low.
   function automatic logic [31:0] lineFromNibs(input logic [31:0] nibs);
      logic [31:0] line;
      line = '0;
      for (int b = 0; b < LL; b++) begin
         logic [3:0] hi, lo;
         hi = 4'((nibs >> (8 * b)) & 32'hF);
         lo = 4'((nibs >> (8 * b + 4)) & 32'hF);
         line = line | ({24'd0, hi, lo} << (8 * b));
      end
      return line;
   endfunction

   function automatic logic [3:0] nibOfLine(input logic [31:0] line, input int k);
      logic [7:0] byteVal;
      byteVal = 8'((line >> (8 * (k / 2))) & 32'hFF);
      return (k % 2 == 0) ? byteVal[7:4] : byteVal[3:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit isI, input bit isW, input logic [LA-1:0] addr,
                                input logic [31:0] data, input logic [1:0] mode);
      rom_mode = mode;
      if (isI) begin
         ic_req  = 1'b1;
         ic_addr = addr;
      end else begin
         dc_req   = 1'b1;
         dc_write = isW;
         dc_addr  = addr;
         dc_wdata = data;
      end
   endtask

   task automatic dropRequests();
      ic_req = 1'b0;
      dc_req = 1'b0;
   endtask

   task automatic waitReq(input string tag);
      for (int i = 0; i < 40 && req !== 1'b1; i++) tick();
      checkOutput({tag, "_reqRise"}, req, 1);
   endtask

   task automatic resetDut();
      reset_n = 1'b0;
      dropRequests();
      dc_write = 1'b0; ic_addr = '0; dc_addr = '0; dc_wdata = '0; rom_mode = 2'b00;
      pad_in = '0; rstrobe_d = 1'b0; wstrobe_i = 1'b0; wstrobe_d = 1'b0;
      repeat (3) tick();
      reset_n = 1'b1;
      tick();
      expIcLine = '0;
      expDcLine = '0;
   endtask

   // Serves a granted read; returns in the done cycle with the request lines untouched.
   task automatic serveRead(input string tag, input bit expI, input logic [LA-1:0] addr,
                            input logic [1:0] mode, input logic [31:0] nibs);
      logic [31:0] line;
      waitReq(tag);
      checkOutput({tag, "_i_d"}, i_d, expI);
      checkOutput({tag, "_write"}, write, 0);
      checkOutput({tag, "_mem"}, mem, refMem(mode, expI, addr));
      checkOutput({tag, "_paddr"}, paddr, addr);
      for (int k = 0; k < 2 * LL; k++) begin
         repeat ($urandom_range(0, 2)) begin
            pad_in = 4'($urandom);
            if (expI) wstrobe_d = 1'b1; else wstrobe_i = 1'b1;
            rstrobe_d = 1'($urandom);
            tick();
            wstrobe_i = 1'b0; wstrobe_d = 1'b0; rstrobe_d = 1'b0;
         end
         pad_in = 4'((nibs >> (4 * k)) & 32'hF);
         if (expI) wstrobe_i = 1'b1; else wstrobe_d = 1'b1;
         tick();
         wstrobe_i = 1'b0; wstrobe_d = 1'b0;
         if (k == 2) checkOutput({tag, "_midReq"}, req, 1);
      end
      line = lineFromNibs(nibs);
      if (expI) expIcLine = line; else expDcLine = line;
      checkOutput({tag, "_icDone"}, ic_done, expI);
      checkOutput({tag, "_dcDone"}, dc_done, !expI);
      checkOutput({tag, "_reqFall"}, req, 0);
      checkOutput({tag, "_icRdata"}, ic_rdata, expIcLine);
      checkOutput({tag, "_dcRdata"}, dc_rdata, expDcLine);
   endtask

   task automatic serveWrite(input string tag, input logic [LA-1:0] addr,
                             input logic [1:0] mode, input logic [31:0] data);
      waitReq(tag);
      checkOutput({tag, "_i_d"}, i_d, 0);
      checkOutput({tag, "_write"}, write, 1);
      checkOutput({tag, "_mem"}, mem, refMem(mode, 1'b0, addr));
      checkOutput({tag, "_paddr"}, paddr, addr);
      for (int k = 0; k < 2 * LL; k++) begin
         repeat ($urandom_range(0, 1)) begin
            wstrobe_d = 1'($urandom);
            tick();
            wstrobe_d = 1'b0;
         end
         checkOutput($sformatf("%s_dwrite%0d", tag, k), dwrite, nibOfLine(data, k));
         rstrobe_d = 1'b1;
         tick();
         rstrobe_d = 1'b0;
      end
      checkOutput({tag, "_dcDone"}, dc_done, 1);
      checkOutput({tag, "_icDone"}, ic_done, 0);
      checkOutput({tag, "_reqFall"}, req, 0);
      checkOutput({tag, "_dcRdata"}, dc_rdata, expDcLine);
   endtask

   task automatic finishTxn(input string tag);
      dropRequests();
      tick();
      checkOutput({tag, "_doneClear"}, {ic_done, dc_done, req}, 3'b000);
   endtask

   initial begin
      logic [LA-1:0] addr;
      logic [31:0]   data;
      logic [1:0]    mode;
      bit            isI, isW;

      resetDut();
      reset_n = 1'b0;
      #2;
      checkOutput("rst_ctrl", {req, i_d, write, ic_done, dc_done, mem}, 7'd0);
      checkOutput("rst_data", {paddr, dwrite, ic_rdata, dc_rdata}, 90'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Strobes while idle must not move anything.
      pad_in = 4'hA; wstrobe_i = 1'b1; wstrobe_d = 1'b1; rstrobe_d = 1'b1;
      repeat (2) tick();
      wstrobe_i = 1'b0; wstrobe_d = 1'b0; rstrobe_d = 1'b0;
      checkOutput("idleStrobe", {req, ic_done, dc_done}, 3'b000);

      applyStimulus(1'b1, 1'b0, 22'h000040, '0, 2'b11);
      serveRead("iRead", 1'b1, 22'h000040, 2'b11, 32'h87654321);
      checkOutput("iRead_line", ic_rdata, 32'h78563412);
      finishTxn("iRead");

      applyStimulus(1'b0, 1'b1, 22'h200004, 32'hDEADBEEF, 2'b00);
      serveWrite("dWrite", 22'h200004, 2'b00, 32'hDEADBEEF);
      finishTxn("dWrite");

      // Both sides requesting from reset: D first, then strict alternation while both stay high.
      resetDut();
      ic_addr = 22'h200000; dc_addr = 22'h200000; dc_write = 1'b0; rom_mode = 2'b11;
      ic_req = 1'b1; dc_req = 1'b1;
      for (int n = 0; n < 4; n++) begin
         isI = (n % 2 == 1);
         serveRead($sformatf("arb%0d", n), isI, 22'h200000, 2'b11, $urandom);
         if (n < 3) begin
            tick();
            checkOutput($sformatf("arbGap%0d", n), req, 1);
         end
      end
      finishTxn("arb");

      rom_mode = 2'b01;
      applyStimulus(1'b1, 1'b0, 22'h200000, '0, 2'b01);
      serveRead("rm01I", 1'b1, 22'h200000, 2'b01, $urandom);
      finishTxn("rm01I");
      applyStimulus(1'b0, 1'b0, 22'h200000, '0, 2'b01);
      serveRead("rm01D", 1'b0, 22'h200000, 2'b01, $urandom);
      finishTxn("rm01D");

      // Reset in the middle of a D read throws the partial line away.
      applyStimulus(1'b0, 1'b0, 22'h123456, '0, 2'b10);
      waitReq("rstMid");
      for (int k = 0; k < 3; k++) begin
         pad_in = 4'($urandom); wstrobe_d = 1'b1;
         tick();
         wstrobe_d = 1'b0;
      end
      reset_n = 1'b0;
      #2;
      checkOutput("rstMid_ctrl", {req, i_d, write, ic_done, dc_done, mem}, 7'd0);
      checkOutput("rstMid_data", {paddr, ic_rdata, dc_rdata}, 86'd0);
      dropRequests();
      tick();
      reset_n = 1'b1;
      expIcLine = '0;
      expDcLine = '0;
      tick();
      applyStimulus(1'b0, 1'b0, 22'h0ABCDE, '0, 2'b10);
      serveRead("postRst", 1'b0, 22'h0ABCDE, 2'b10, $urandom);
      finishTxn("postRst");

      for (int t = 0; t < 16; t++) begin
         isI  = 1'($urandom);
         isW  = !isI && 1'($urandom);
         addr = LA'($urandom);
         data = $urandom;
         mode = 2'($urandom);
         applyStimulus(isI, isW, addr, data, mode);
         if (isW) serveWrite($sformatf("rnd%0d", t), addr, mode, data);
         else     serveRead($sformatf("rnd%0d", t), isI, addr, mode, $urandom);
         finishTxn($sformatf("rnd%0d", t));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
